// File: rtl/pcie_tx_pkg.sv
// ============================================================================
// Module  : pcie_tx_pkg
// Purpose : Shared types and field positions for the PCIE ingress word source.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pcie_tx_pkg;

  // Burst sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_PAUSE = 2'd2
  } tx_state_t;

  // Word layout: {class, dest, payload}
  localparam int CLASS_MSB = 11;
  localparam int CLASS_LSB = 10;
  localparam int DEST_MSB  = 9;
  localparam int DEST_LSB  = 8;
  localparam int PAYLOAD_W = 8;

  localparam int NUM_DEST = 4;

  // Statistics index codes; 0..3 select a destination counter
  localparam logic [2:0] IDX_TOTAL = 3'd4;

  // Assemble one ingress word from its fields
  function automatic logic [11:0] pack_word(input logic [1:0] cls,
                                            input logic [1:0] dst,
                                            input logic [PAYLOAD_W-1:0] payload);
    return {cls, dst, payload};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_stat_counters.sv
// ============================================================================
// Module  : tx_stat_counters
// Purpose : Per-destination and total sent-word counters with a req/idx
//           registered read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_stat_counters
  import pcie_tx_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [1:0]       inc_dest,
  input  logic             req,
  input  logic [2:0]       idx,
  output logic [CNT_W-1:0] data,
  output logic             valid
);

  logic [CNT_W-1:0] cnt [NUM_DEST];
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] rd_sel;

  // One wrapping counter per destination
  for (genvar d = 0; d < NUM_DEST; d++) begin : g_dest
    // Count words pushed toward destination d
    always_ff @(posedge clk) begin
      if (reset)
        cnt[d] <= '0;
      else if (inc && (inc_dest == 2'(d)))
        cnt[d] <= cnt[d] + CNT_W'(1);
    end
  end

  // Count every pushed word regardless of destination
  always_ff @(posedge clk) begin
    if (reset)
      total <= '0;
    else if (inc)
      total <= total + CNT_W'(1);
  end

  // Select the counter addressed by idx; unused codes read as zero
  always_comb begin
    rd_sel = '0;
    if (!idx[2])
      rd_sel = cnt[idx[1:0]];
    else if (idx == IDX_TOTAL)
      rd_sel = total;
  end

  // Register the read: value sampled before this cycle's increment, held until next read
  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= req;
      if (req)
        data <= rd_sel;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pcie_word_tx.sv
// ============================================================================
// Module  : pcie_word_tx
// Purpose : Burst-command traffic source for the PCIE ingress FIFO, paced by
//           almost_full/full, with per-destination sent-word statistics.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pcie_word_tx
  import pcie_tx_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_class,
  input  logic [1:0]        cmd_dest,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [7:0]        cmd_seed,
  input  logic              abort,
  input  logic              fifo_almost_full,
  input  logic              fifo_full,
  output logic              push,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  input  logic              req,
  input  logic [2:0]        idx,
  output logic [CNT_W-1:0]  data,
  output logic              valid
);

  // One extra bit so a zero length field can hold 2**LEN_W
  localparam int REM_W = LEN_W + 1;

  tx_state_t              state, state_nxt;
  logic [1:0]             cls, dst;
  logic [PAYLOAD_W-1:0]   payload;
  logic [REM_W-1:0]       remaining;
  logic                   load, send_word, end_burst;
  logic                   fifo_open;

  assign fifo_open = !fifo_almost_full && !fifo_full;

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and control decode; abort takes priority over pushing
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    send_word = 1'b0;
    end_burst = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          load      = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort) begin
          end_burst = 1'b1;
          state_nxt = ST_IDLE;
        end else if (fifo_open) begin
          send_word = 1'b1;
          if (remaining == REM_W'(1)) begin
            end_burst = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          end_burst = 1'b1;
          state_nxt = ST_IDLE;
        end else if (fifo_open) begin
          state_nxt = ST_SEND;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Burst datapath and registered FIFO write port
  always_ff @(posedge clk) begin
    if (reset) begin
      cls       <= '0;
      dst       <= '0;
      payload   <= '0;
      remaining <= '0;
      push      <= 1'b0;
      data_out  <= '0;
      done      <= 1'b0;
    end else begin
      push <= send_word;
      done <= end_burst;
      if (load) begin
        cls       <= cmd_class;
        dst       <= cmd_dest;
        payload   <= cmd_seed;
        remaining <= (cmd_len == '0) ? REM_W'(1 << LEN_W) : {1'b0, cmd_len};
      end
      if (send_word) begin
        data_out  <= DATA_W'(pack_word(cls, dst, payload));
        payload   <= payload + PAYLOAD_W'(1);
        remaining <= remaining - REM_W'(1);
      end
    end
  end

  tx_stat_counters #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk      (clk),
    .reset    (reset),
    .inc      (push),
    .inc_dest (data_out[DEST_MSB:DEST_LSB]),
    .req      (req),
    .idx      (idx),
    .data     (data),
    .valid    (valid)
  );

endmodule

`default_nettype wire
